// File: rtl/spi_bus_arbiter_pkg.sv
// Shared types for the SPI bus arbiter: FSM state encodings and requester indices.
package spi_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5
  } arb_state_t;

  localparam int REQ_EEPROM = 0;
  localparam int REQ_FLASH  = 1;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_bus_arbiter_shift_engine.sv
// SPI mode 0 byte shifter: divider, bit counter, MOSI/MISO shift registers,
// start/done handshake. One byte takes 16*CLK_DIV clocks from start.
module spi_shift_engine
  import spi_bus_arbiter_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       spi_q,
  output logic       spi_c,
  output logic       spi_d,
  output logic       done,
  output logic [7:0] rx_byte
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic          busy;
  logic [DW-1:0] div;
  logic [2:0]    bit_cnt;
  logic [7:0]    tx_sh;
  logic [7:0]    rx_sh;
  logic [7:0]    rx_next;
  logic          div_end;

  assign div_end = (div == DW'(CLK_DIV - 1));

  // MISO is captured in the first clock of each high phase; with CLK_DIV=1
  // that is also the final cycle, so done must see the freshly shifted byte.
  always_comb begin
    rx_next = rx_sh;
    if (spi_c && div == '0) rx_next = {rx_sh[6:0], spi_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= 1'b0;
      div     <= '0;
      bit_cnt <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      rx_byte <= '0;
      spi_c   <= 1'b0;
      spi_d   <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        busy    <= 1'b1;
        tx_sh   <= tx_byte;
        spi_d   <= tx_byte[7];
        spi_c   <= 1'b0;
        div     <= '0;
        bit_cnt <= '0;
      end else if (busy) begin
        rx_sh <= rx_next;
        if (!div_end) begin
          div <= div + DW'(1);
        end else begin
          div <= '0;
          if (!spi_c) begin
            spi_c <= 1'b1;
          end else begin
            spi_c <= 1'b0;
            if (bit_cnt == 3'd7) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              rx_byte <= rx_next;
              spi_d   <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx_sh   <= {tx_sh[6:0], 1'b0};
              spi_d   <= tx_sh[6];
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Two-requester SPI bus arbiter (EEPROM=0, flash=1): round-robin grant, CS
// timing, byte transfers via spi_shift_engine. Optional: SPI_TIMEOUT_EN.
module spi_bus_arbiter
  import spi_bus_arbiter_pkg::*;
#(
  parameter int CLK_DIV      = 2,
  parameter int CS_SETUP_CYC = 4,
  parameter int CS_GAP_CYC   = 8,
  parameter int TIMEOUT_CYC  = 4096
) (
  input  logic        clk_dot4x,
  input  logic        rst,
  input  logic [1:0]  req,
  output logic [1:0]  gnt,
  input  logic [1:0]  tx_valid,
  input  logic [15:0] tx_data,
  output logic [1:0]  tx_ready,
  output logic [1:0]  rx_valid,
  output logic [7:0]  rx_data,
  output logic        timeout,
  output logic        flash_s,
  output logic        eeprom_s,
  output logic        spi_c,
  output logic        spi_d,
  input  logic        spi_q
);

  localparam int CNT_MAX = max2(max2(CLK_DIV, CS_SETUP_CYC), max2(CS_GAP_CYC, TIMEOUT_CYC));
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  arb_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             g;
  logic             last_gnt;
  logic             pick;
  logic [1:0]       req_eff;
  logic             start;
  logic             done;
  logic [7:0]       tx_byte;
  logic [7:0]       rx_byte;

`ifdef SPI_TIMEOUT_EN
  // A requester whose grant was forcibly revoked stays locked out until it drops req.
  logic [1:0] blocked;
  assign req_eff = req & ~blocked;
`else
  assign req_eff = req;
  assign timeout = 1'b0;
`endif

  assign pick     = (req_eff == 2'b11) ? ~last_gnt : req_eff[1];
  assign tx_byte  = g ? tx_data[15:8] : tx_data[7:0];
  assign start    = (state == ST_WAIT) && tx_valid[g] && tx_ready[g];
  assign rx_valid = done ? gnt : 2'b00;
  assign rx_data  = rx_byte;

  always_ff @(posedge clk_dot4x or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      g        <= 1'b0;
      last_gnt <= 1'b1;
      gnt      <= 2'b00;
      tx_ready <= 2'b00;
      flash_s  <= 1'b1;
      eeprom_s <= 1'b1;
`ifdef SPI_TIMEOUT_EN
      timeout  <= 1'b0;
      blocked  <= 2'b00;
`endif
    end else begin
`ifdef SPI_TIMEOUT_EN
      timeout <= 1'b0;
      blocked <= blocked & req;
`endif
      case (state)
        ST_IDLE: if (|req_eff) begin
          g        <= pick;
          gnt      <= pick ? 2'b10 : 2'b01;
          eeprom_s <= ~(pick == 1'(REQ_EEPROM));
          flash_s  <= ~(pick == 1'(REQ_FLASH));
          cnt      <= '0;
          state    <= ST_SETUP;
        end
        ST_SETUP: if (cnt == CNT_W'(CS_SETUP_CYC - 1)) begin
          state    <= ST_WAIT;
          tx_ready <= gnt;
          cnt      <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
        ST_WAIT: if (start) begin
          state    <= ST_SHIFT;
          tx_ready <= 2'b00;
        end else if (!req[g]) begin
          state    <= ST_HOLD;
          tx_ready <= 2'b00;
          cnt      <= '0;
        end
`ifdef SPI_TIMEOUT_EN
        else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          state      <= ST_HOLD;
          tx_ready   <= 2'b00;
          cnt        <= '0;
          timeout    <= 1'b1;
          blocked[g] <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
`endif
        // A req drop mid-byte is only acted on once the byte has completed.
        ST_SHIFT: if (done) begin
          cnt <= '0;
          if (req[g]) begin
            state    <= ST_WAIT;
            tx_ready <= gnt;
          end else begin
            state <= ST_HOLD;
          end
        end
        ST_HOLD: if (cnt == CNT_W'(CLK_DIV - 1)) begin
          state    <= ST_GAP;
          cnt      <= '0;
          gnt      <= 2'b00;
          flash_s  <= 1'b1;
          eeprom_s <= 1'b1;
          last_gnt <= g;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
        ST_GAP: if (cnt == CNT_W'(CS_GAP_CYC - 1)) begin
          state <= ST_IDLE;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  spi_shift_engine #(.CLK_DIV(CLK_DIV)) u_shift (
    .clk     (clk_dot4x),
    .rst     (rst),
    .start   (start),
    .tx_byte (tx_byte),
    .spi_q   (spi_q),
    .spi_c   (spi_c),
    .spi_d   (spi_d),
    .done    (done),
    .rx_byte (rx_byte)
  );

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter; SPI slave modelled in the stimulus process.
module tb_spi_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [1:0]  gnt;
  logic [1:0]  tx_valid;
  logic [15:0] tx_data;
  logic [1:0]  tx_ready;
  logic [1:0]  rx_valid;
  logic [7:0]  rx_data;
  logic        timeout;
  logic        flash_s, eeprom_s, spi_c, spi_d, spi_q;

  int n_chk = 0;
  int n_bad = 0;

  // monitor state, owned by the stimulus process only
  logic [7:0] slv, mosi_sh, last_rx;
  logic [1:0] last_rxv;
  logic       prev_c;
  int rxv_cnt, both_low, hi_run, min_gap, ee_breaks, to_cnt;
  bit saw_low, mon_ee;

  spi_bus_arbiter #(.CLK_DIV(2), .CS_SETUP_CYC(4), .CS_GAP_CYC(8), .TIMEOUT_CYC(16)) dut (
    .clk_dot4x(clk), .rst(rst), .req(req), .gnt(gnt), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data),
    .timeout(timeout), .flash_s(flash_s), .eeprom_s(eeprom_s), .spi_c(spi_c),
    .spi_d(spi_d), .spi_q(spi_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (!flash_s && !eeprom_s) both_low++;
    if (mon_ee && eeprom_s) ee_breaks++;
    if (timeout) to_cnt++;
    if (spi_c && !prev_c) mosi_sh = {mosi_sh[6:0], spi_d};
    if (!spi_c && prev_c) slv = {slv[6:0], 1'b0};
    prev_c = spi_c;
    spi_q  = slv[7];
    if (rx_valid != 2'b00) begin
      rxv_cnt++;
      last_rxv = rx_valid;
      last_rx  = rx_data;
    end
    if (flash_s && eeprom_s) hi_run++;
    else begin
      if (saw_low && hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
      saw_low = 1'b1;
      hi_run  = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 2'b00;
    tx_valid = 2'b00;
    tick();
    tick();
    rst = 1'b0;
    prev_c = 1'b0;
  endtask

  task automatic wait_ready(input int g);
    int n;
    n = 0;
    while (!tx_ready[g] && n < 60) begin
      tick();
      n++;
    end
    if (!tx_ready[g]) chk("wait_ready_bound", 0, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (gnt != 2'b00 && n < 60) begin
      tick();
      n++;
    end
    if (gnt != 2'b00) chk("wait_idle_bound", 0, 1);
    repeat (12) tick();
  endtask

  // handshake one byte; the posedge inside tick() is the accepting edge
  task automatic send(input int g, input logic [7:0] tx, input logic [7:0] sv);
    slv   = sv;
    spi_q = slv[7];
    tx_data = {tx, tx};
    tx_valid[g] = 1'b1;
    tick();
    tx_valid = 2'b00;
  endtask

  task automatic wait_rx(input int g, input int drop_at, output int lat);
    lat = 0;
    rxv_cnt = 0;
    while (lat < 100) begin
      tick();
      lat++;
      if (lat == drop_at) req = 2'b00;
      if (rx_valid[g]) break;
    end
  endtask

  initial begin
    int lat, n;
    rst = 1'b1; req = 2'b00; tx_valid = 2'b00; tx_data = 16'h0; spi_q = 1'b0;
    slv = 8'h00; mosi_sh = 8'h00; last_rx = 8'h00; last_rxv = 2'b00; prev_c = 1'b0;
    rxv_cnt = 0; both_low = 0; hi_run = 0; min_gap = 999; ee_breaks = 0; to_cnt = 0;
    saw_low = 1'b0; mon_ee = 1'b0;

    // reset state
    #1;
    chk("rst_gnt", gnt, 2'b00);
    do_reset();
    chk("rst_tx_ready", tx_ready, 2'b00);
    chk("rst_rx_valid", rx_valid, 2'b00);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_cs", {flash_s, eeprom_s}, 2'b11);
    chk("rst_spi", {spi_c, spi_d}, 2'b00);

    // 1: flash byte 0xA5 out, 0x3C back
    req = 2'b10;
    wait_ready(1);
    chk("t1_cs", {flash_s, eeprom_s}, 2'b01);
    chk("t1_gnt", gnt, 2'b10);
    send(1, 8'hA5, 8'h3C);
    wait_rx(1, 0, lat);
    chk("t1_latency", lat, 32);
    chk("t1_mosi", mosi_sh, 8'hA5);
    chk("t1_rx_valid", last_rxv, 2'b10);
    chk("t1_rx_data", last_rx, 8'h3C);
    req = 2'b00;
    wait_idle();
    chk("t1_released_cs", {flash_s, eeprom_s}, 2'b11);

    // 2: simultaneous requests, round robin
    do_reset();
    both_low = 0; hi_run = 0; min_gap = 999; saw_low = 1'b0;
    req = 2'b11;
    n = 0;
    while (gnt == 2'b00 && n < 20) begin tick(); n++; end
    chk("t2_first_gnt", gnt, 2'b01);
    wait_ready(0);
    req = 2'b10;
    tick();
    req = 2'b11;
    n = 0;
    while (gnt != 2'b10 && n < 40) begin tick(); n++; end
    chk("t2_second_gnt", gnt, 2'b10);
    chk("t2_cs_overlap", both_low, 0);
    chk("t2_min_gap_ge8", (min_gap >= 8) ? 1 : 0, 1);
    req = 2'b00;
    wait_idle();

    // 3: three-byte EEPROM burst under one CS
    rxv_cnt = 0;
    req = 2'b01;
    wait_ready(0);
    mon_ee = 1'b1; ee_breaks = 0;
    send(0, 8'h03, 8'h11);
    wait_rx(0, 0, lat);
    chk("t3_rx0", last_rx, 8'h11);
    wait_ready(0);
    send(0, 8'h00, 8'h22);
    wait_rx(0, 0, lat);
    chk("t3_rx1", last_rx, 8'h22);
    chk("t3_mosi1", mosi_sh, 8'h00);
    wait_ready(0);
    send(0, 8'h10, 8'h33);
    wait_rx(0, 0, lat);
    chk("t3_rx2", last_rx, 8'h33);
    chk("t3_mosi2", mosi_sh, 8'h10);
    chk("t3_rxv_src", last_rxv, 2'b01);
    mon_ee = 1'b0;
    chk("t3_cs_held", ee_breaks, 0);
    req = 2'b00;
    n = 0;
    while (!eeprom_s && n < 20) begin tick(); n++; end
    chk("t3_cs_tail", n - 1, 2);
    wait_idle();

    // 4: drop req[1] mid-byte
    req = 2'b10;
    wait_ready(1);
    send(1, 8'h5A, 8'hC3);
    wait_rx(1, 10, lat);
    chk("t4_latency", lat, 32);
    chk("t4_rx_data", last_rx, 8'hC3);
    repeat (20) tick();
    chk("t4_rx_pulses", rxv_cnt, 1);
    chk("t4_released", {gnt, flash_s}, 3'b001);

    // 5: reset during bit 4
    wait_idle();
    req = 2'b01;
    wait_ready(0);
    send(0, 8'hFF, 8'hFF);
    rxv_cnt = 0;
    repeat (17) tick();
    chk("t5_midbyte_cs", eeprom_s, 1'b0);
    rst = 1'b1;
    #1;
    chk("t5_rst_gnt", gnt, 2'b00);
    chk("t5_rst_cs", {flash_s, eeprom_s}, 2'b11);
    chk("t5_rst_spi_c", spi_c, 1'b0);
    repeat (3) tick();
    rst = 1'b0;
    req = 2'b00;
    repeat (40) tick();
    chk("t5_no_rx", rxv_cnt, 0);

    // 6: granted but idle
    to_cnt = 0;
    req = 2'b01;
    wait_ready(0);
`ifdef SPI_TIMEOUT_EN
    n = 1;
    while (!timeout && n < 100) begin
      tick();
      if (tx_ready[0]) n++;
    end
    chk("t6_timeout_seen", timeout, 1'b1);
    chk("t6_wait_cycles", n, 16);
    repeat (3) tick();
    chk("t6_cs_high", eeprom_s, 1'b1);
    repeat (30) tick();
    chk("t6_locked_out", gnt, 2'b00);
    chk("t6_one_pulse", to_cnt, 1);
`else
    repeat (1000) tick();
    chk("t6_gnt_held", gnt, 2'b01);
    chk("t6_cs_held", eeprom_s, 1'b0);
    chk("t6_no_timeout", to_cnt, 0);
`endif
    req = 2'b00;
    repeat (20) tick();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
